// File: rtl/sequenciador_instrucao_pkg.sv
// Shared constants for the multicycle sequencer: opcode map used by the control
// unit and the sequencer state encoding.
package sequenciador_instrucao_pkg;

    localparam logic [4:0] OP_NOP = 5'b00000;
    localparam logic [4:0] OP_HLT = 5'b00001;
    localparam logic [4:0] OP_IN  = 5'b00010;
    localparam logic [4:0] OP_OUT = 5'b00011;
    localparam logic [4:0] OP_ADD = 5'b00100;
    localparam logic [4:0] OP_SUB = 5'b00101;
    localparam logic [4:0] OP_LD  = 5'b00110;
    localparam logic [4:0] OP_ST  = 5'b00111;
    localparam logic [4:0] OP_JMP = 5'b01000;
    localparam logic [4:0] OP_JZ  = 5'b01001;
    localparam logic [4:0] OP_JN  = 5'b01010;

    typedef enum logic [2:0] {
        INICIO         = 3'd0,
        BUSCA          = 3'd1,
        CARREGA_IR     = 3'd2,
        EXECUTA        = 3'd3,
        ESPERA_ENTRADA = 3'd4,
        ESCRITA        = 3'd5,
        PARADO         = 3'd6
    } estado_t;

    function automatic logic eh_entrada(input logic [4:0] op);
        return (op == OP_IN);
    endfunction

endpackage

// File: rtl/sequenciador_instrucao.sv
// Fetch/execute sequencer: owns pc and the retired-instruction counter, turns the
// control unit's requests into one-cycle commit pulses, waits on IN, parks on HLT.
module sequenciador_instrucao
    import sequenciador_instrucao_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       opcode,
    input  logic             halt,
    input  logic             jump,
    input  logic [31:0]      jumpE,
    input  logic             escreveR,
    input  logic             escreveM,
    input  logic             escreverOut,
    input  logic             entrada_valida,
    output logic [PC_W-1:0]  pc,
    output logic             ir_load,
    output logic             wr_reg,
    output logic             wr_mem,
    output logic             wr_out,
    output logic             entrada_ack,
    output logic             esperando,
    output logic             parado,
    output logic [CNT_W-1:0] retiradas
);

    estado_t            estado_q, estado_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   ret_q, ret_d;

    // Jump targets wider than the instruction memory are simply truncated.
    logic unused_jumpe_alto_s;
    assign unused_jumpe_alto_s = ^jumpE[31:PC_W];

    // State, pc and retired counter; reset aborts any instruction in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIO;
            pc_q     <= '0;
            ret_q    <= '0;
        end else begin
            estado_q <= estado_d;
            pc_q     <= pc_d;
            ret_q    <= ret_d;
        end
    end

    // Next-state logic and Moore decodes; commit pulses only in ESCRITA.
    always_comb begin
        estado_d    = estado_q;
        pc_d        = pc_q;
        ret_d       = ret_q;
        ir_load     = 1'b0;
        wr_reg      = 1'b0;
        wr_mem      = 1'b0;
        wr_out      = 1'b0;
        entrada_ack = 1'b0;
        esperando   = 1'b0;
        parado      = 1'b0;
        case (estado_q)
            INICIO: begin
                estado_d = BUSCA;
            end
            BUSCA: begin
                estado_d = CARREGA_IR;
            end
            CARREGA_IR: begin
                ir_load  = 1'b1;
                estado_d = EXECUTA;
            end
            EXECUTA: begin
                // halt wins over every other request carried by the same opcode
                if (halt) begin
                    estado_d = PARADO;
                end else if (eh_entrada(opcode) && !entrada_valida) begin
                    estado_d = ESPERA_ENTRADA;
                end else begin
                    estado_d = ESCRITA;
                end
            end
            ESPERA_ENTRADA: begin
                esperando = 1'b1;
                if (entrada_valida) begin
                    estado_d = ESCRITA;
                end else begin
                    estado_d = ESPERA_ENTRADA;
                end
            end
            ESCRITA: begin
                wr_reg      = escreveR;
                wr_mem      = escreveM;
                wr_out      = escreverOut;
                entrada_ack = eh_entrada(opcode);
                if (jump) begin
                    pc_d = jumpE[PC_W-1:0];
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
                ret_d    = ret_q + CNT_W'(1);
                estado_d = BUSCA;
            end
            PARADO: begin
                parado   = 1'b1;
                estado_d = PARADO;
            end
            default: begin
                estado_d = INICIO;
            end
        endcase
    end

    assign pc        = pc_q;
    assign retiradas = ret_q;

endmodule

// File: tb/tb_sequenciador_instrucao.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected per-cycle outputs; one compare process checks them every cycle.
module tb_sequenciador_instrucao;
    import sequenciador_instrucao_pkg::*;

    localparam int PC_W  = 10;
    localparam int CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [4:0]       opcode = 5'd0;
    logic             halt = 1'b0;
    logic             jump = 1'b0;
    logic [31:0]      jumpE = 32'd0;
    logic             escreveR = 1'b0;
    logic             escreveM = 1'b0;
    logic             escreverOut = 1'b0;
    logic             entrada_valida = 1'b0;
    logic [PC_W-1:0]  pc;
    logic             ir_load, wr_reg, wr_mem, wr_out, entrada_ack, esperando, parado;
    logic [CNT_W-1:0] retiradas;

    sequenciador_instrucao #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .halt(halt), .jump(jump),
        .jumpE(jumpE), .escreveR(escreveR), .escreveM(escreveM),
        .escreverOut(escreverOut), .entrada_valida(entrada_valida), .pc(pc),
        .ir_load(ir_load), .wr_reg(wr_reg), .wr_mem(wr_mem), .wr_out(wr_out),
        .entrada_ack(entrada_ack), .esperando(esperando), .parado(parado),
        .retiradas(retiradas)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             il, wr, wm, wo, ack, esp, par;
        logic [CNT_W-1:0] ret;
    } obs_t;

    obs_t             exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    logic [PC_W-1:0]  m_pc = '0;
    logic [CNT_W-1:0] m_ret = '0;

    // Compare process: one expected output vector per checked cycle.
    always @(negedge clock) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{pc: pc, il: ir_load, wr: wr_reg, wm: wr_mem, wo: wr_out,
                  ack: entrada_ack, esp: esperando, par: parado, ret: retiradas};
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL cycle_outputs t=%0t actual pc=%h il=%b wr/wm/wo=%b%b%b ack=%b esp=%b par=%b ret=%0d required pc=%h il=%b wr/wm/wo=%b%b%b ack=%b esp=%b par=%b ret=%0d",
                         $time, a.pc, a.il, a.wr, a.wm, a.wo, a.ack, a.esp, a.par, a.ret,
                         e.pc, e.il, e.wr, e.wm, e.wo, e.ack, e.esp, e.par, e.ret);
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic garbage();
        opcode         = 5'($urandom);
        halt           = 1'($urandom);
        jump           = 1'($urandom);
        jumpE          = $urandom;
        escreveR       = 1'($urandom);
        escreveM       = 1'($urandom);
        escreverOut    = 1'($urandom);
        entrada_valida = 1'($urandom);
    endtask

    task automatic push(input logic il, input logic wr, input logic wm, input logic wo,
                        input logic ack, input logic esp, input logic par);
        obs_t e;
        e = '{pc: m_pc, il: il, wr: wr, wm: wm, wo: wo, ack: ack, esp: esp, par: par, ret: m_ret};
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            garbage();
            reset = 1'b1;
        end
        tick();
        reset = 1'b0;
        garbage();
        m_pc  = '0;
        m_ret = '0;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One instruction: 4 cycles plus nwait; abort>0 asserts reset on that wait cycle.
    task automatic run_instr(input logic [4:0] op, input logic er, input logic em,
                             input logic eo, input logic jp, input logic [31:0] je,
                             input int nwait, input int abort);
        tick(); garbage();
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); garbage();
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        opcode = op; halt = 1'b0; jump = jp; jumpE = je;
        escreveR = er; escreveM = em; escreverOut = eo;
        if (op == OP_IN) entrada_valida = (nwait == 0);
        else entrada_valida = 1'($urandom);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (op == OP_IN) begin
            for (int i = 1; i <= nwait; i++) begin
                tick();
                entrada_valida = (i == nwait);
                if (i == abort) begin
                    reset = 1'b1;
                    entrada_valida = 1'b1;
                    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                    return;
                end
                push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            end
        end
        tick();
        entrada_valida = 1'($urandom);
        push(1'b0, er, em, eo, (op == OP_IN), 1'b0, 1'b0);
        m_pc  = jp ? je[PC_W-1:0] : m_pc + 10'd1;
        m_ret = m_ret + 32'd1;
    endtask

    task automatic run_halt(input int park);
        tick(); garbage();
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); garbage();
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); garbage();
        halt = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < park; i++) begin
            tick(); garbage();
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        logic [4:0] op;
        int         nw;
        do_reset(3);
        chk("reset_pc", m_pc, 0);

        repeat (3) run_instr(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        chk("nop_ret", m_ret, 3);
        chk("nop_pc", m_pc, 3);

        run_instr(OP_JMP, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5, 0, 0);
        run_instr(OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        chk("add_pc", m_pc, 6);

        run_instr(OP_IN, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 7, 0);
        run_instr(OP_IN, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        chk("in_pc", m_pc, 8);

        run_instr(OP_JMP, 1'b0, 1'b0, 1'b0, 1'b1, 32'd12, 0, 0);
        run_instr(OP_JZ, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0403, 0, 0);
        chk("jz_pc", m_pc, 3);
        run_instr(OP_JMP, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, 0);
        chk("jmp_max_pc", m_pc, 10'h3FF);
        run_instr(OP_OUT, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 0, 0);
        chk("wrap_pc", m_pc, 0);
        chk("ret_11", m_ret, 11);

        for (int k = 0; k < 40; k++) begin
            op = 5'($urandom);
            while (op == OP_HLT) op = 5'($urandom);
            if ($urandom_range(3, 0) == 0) op = OP_IN;
            nw = (op == OP_IN) ? int'($urandom_range(5, 0)) : 0;
            run_instr(op, 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(3, 0) == 0), $urandom, nw, 0);
        end

        run_instr(OP_JMP, 1'b0, 1'b0, 1'b0, 1'b1, 32'd20, 0, 0);
        run_halt(50);
        chk("halt_pc", m_pc, 20);
        do_reset(2);
        run_instr(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        chk("after_halt_pc", m_pc, 1);

        run_instr(OP_IN, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 5, 3);
        do_reset(0);
        run_instr(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 0, 0);
        chk("after_abort_ret", m_ret, 1);

        tick();
        repeat (2) @(negedge clock);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
